// File: rtl/mac_seq_ctrl.sv
// Sequencer feeding one mac unit: streams N_INPUTS feature/weight pairs, accumulates products, adds bias.
// Optional MAC_SEQ_RELU_EN clamps negative neuron outputs to zero in the BIAS stage.
module mac_seq_ctrl #(
    parameter int N_INPUTS = 784,
    parameter int F_ADDR_W = 10,
    parameter int W_ADDR_W = 13,
    parameter int ACC_W    = 32
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    input  logic [W_ADDR_W-1:0]        weight_base,
    input  logic signed [15:0]         bias,
    output logic                       busy,
    output logic                       feat_rd_en,
    output logic [F_ADDR_W-1:0]        feat_rd_addr,
    input  logic [7:0]                 feat_rdata,
    output logic                       wgt_rd_en,
    output logic [W_ADDR_W-1:0]        wgt_rd_addr,
    input  logic signed [7:0]          wgt_rdata,
    output logic                       mac_en,
    output logic [7:0]                 mac_feature,
    output logic signed [7:0]          mac_weight,
    input  logic signed [16:0]         mac_result,
    input  logic                       mac_done,
    output logic signed [ACC_W-1:0]    out_result,
    output logic                       out_valid
);

    localparam int CNT_W = $clog2(N_INPUTS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_INPUTS - 1);
    localparam logic [CNT_W-1:0] ALL_DONE = CNT_W'(N_INPUTS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_BIAS  = 2'd3;

    logic [1:0]              state_reg, state_next;
    logic [CNT_W-1:0]        issue_cnt_reg;
    logic [CNT_W-1:0]        done_cnt_reg, done_cnt_next;
    logic signed [ACC_W-1:0] acc_reg, acc_next;
    logic [W_ADDR_W-1:0]     wbase_reg;
    logic signed [15:0]      bias_reg;
    logic                    mac_en_reg;
    logic signed [ACC_W-1:0] out_result_reg, result_next;
    logic                    out_valid_reg;

    logic                    start_accept;
    logic                    done_accept;
    logic signed [ACC_W-1:0] bias_sum;

    assign start_accept = start && (state_reg == S_IDLE);
    assign done_accept  = mac_done && (state_reg != S_IDLE);

    assign busy         = (state_reg != S_IDLE);
    assign feat_rd_en   = (state_reg == S_ISSUE);
    assign wgt_rd_en    = (state_reg == S_ISSUE);
    assign feat_rd_addr = F_ADDR_W'(issue_cnt_reg);
    assign wgt_rd_addr  = wbase_reg + W_ADDR_W'(issue_cnt_reg);

    // RAM data lines up with mac_en; gating keeps the mac inputs quiet between runs.
    assign mac_en      = mac_en_reg;
    assign mac_feature = mac_en_reg ? feat_rdata : 8'd0;
    assign mac_weight  = mac_en_reg ? wgt_rdata  : 8'sd0;

    assign out_result = out_result_reg;
    assign out_valid  = out_valid_reg;

    always_comb begin
        done_cnt_next = done_cnt_reg;
        acc_next      = acc_reg;
        if (done_accept) begin
            done_cnt_next = done_cnt_reg + CNT_W'(1);
            acc_next      = acc_reg + {{(ACC_W-17){mac_result[16]}}, mac_result};
        end
    end

    assign bias_sum = acc_reg + {{(ACC_W-16){bias_reg[15]}}, bias_reg};

    always_comb begin
`ifdef MAC_SEQ_RELU_EN
        result_next = bias_sum[ACC_W-1] ? '0 : bias_sum;
`else
        result_next = bias_sum;
`endif
    end

    // DRAIN looks at the count including this cycle's done so BIAS follows the last product directly.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start)                        state_next = S_ISSUE;
            S_ISSUE: if (issue_cnt_reg == LAST_IDX)    state_next = S_DRAIN;
            S_DRAIN: if (done_cnt_next == ALL_DONE)    state_next = S_BIAS;
            S_BIAS:                                    state_next = S_IDLE;
            default:                                   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg      <= S_IDLE;
            issue_cnt_reg  <= '0;
            done_cnt_reg   <= '0;
            acc_reg        <= '0;
            wbase_reg      <= '0;
            bias_reg       <= '0;
            mac_en_reg     <= 1'b0;
            out_result_reg <= '0;
            out_valid_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mac_en_reg    <= feat_rd_en;
            out_valid_reg <= (state_reg == S_BIAS);
            if (start_accept) begin
                wbase_reg     <= weight_base;
                bias_reg      <= bias;
                issue_cnt_reg <= '0;
                done_cnt_reg  <= '0;
                acc_reg       <= '0;
            end else begin
                done_cnt_reg <= done_cnt_next;
                acc_reg      <= acc_next;
                if ((state_reg == S_ISSUE) && (issue_cnt_reg != LAST_IDX))
                    issue_cnt_reg <= issue_cnt_reg + CNT_W'(1);
            end
            if (state_reg == S_BIAS)
                out_result_reg <= result_next;
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl: a 4-input instance for timing/corner cases and a 784-input instance
// against a reference sum; results are scoreboarded by expected value and expected out_valid cycle.
module tb_mac_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    logic [7:0]        fmem [0:1023];
    logic signed [7:0] wmem [0:8191];

    // ---------------- instance A: N_INPUTS = 4 ----------------
    logic               a_start, a_busy, a_fen, a_wen, a_men, a_mdone, a_ov;
    logic [12:0]        a_wb, a_waddr;
    logic signed [15:0] a_bias;
    logic [9:0]         a_faddr;
    logic [7:0]         a_frd, a_mf;
    logic signed [7:0]  a_wrd, a_mw;
    logic signed [16:0] a_mres, a_p_r;
    logic               a_p_v;
    logic signed [31:0] a_res;

    mac_seq_ctrl #(.N_INPUTS(4), .F_ADDR_W(10), .W_ADDR_W(13), .ACC_W(32)) u_a (
        .clk(clk), .rstn(rstn), .start(a_start), .weight_base(a_wb), .bias(a_bias),
        .busy(a_busy), .feat_rd_en(a_fen), .feat_rd_addr(a_faddr), .feat_rdata(a_frd),
        .wgt_rd_en(a_wen), .wgt_rd_addr(a_waddr), .wgt_rdata(a_wrd),
        .mac_en(a_men), .mac_feature(a_mf), .mac_weight(a_mw),
        .mac_result(a_mres), .mac_done(a_mdone), .out_result(a_res), .out_valid(a_ov)
    );

    // ---------------- instance B: N_INPUTS = 784 ----------------
    logic               b_start, b_busy, b_fen, b_wen, b_men, b_mdone, b_ov;
    logic [12:0]        b_wb, b_waddr;
    logic signed [15:0] b_bias;
    logic [9:0]         b_faddr;
    logic [7:0]         b_frd, b_mf;
    logic signed [7:0]  b_wrd, b_mw;
    logic signed [16:0] b_mres, b_p_r;
    logic               b_p_v;
    logic signed [31:0] b_res;

    mac_seq_ctrl #(.N_INPUTS(784), .F_ADDR_W(10), .W_ADDR_W(13), .ACC_W(32)) u_b (
        .clk(clk), .rstn(rstn), .start(b_start), .weight_base(b_wb), .bias(b_bias),
        .busy(b_busy), .feat_rd_en(b_fen), .feat_rd_addr(b_faddr), .feat_rdata(b_frd),
        .wgt_rd_en(b_wen), .wgt_rd_addr(b_waddr), .wgt_rdata(b_wrd),
        .mac_en(b_men), .mac_feature(b_mf), .mac_weight(b_mw),
        .mac_result(b_mres), .mac_done(b_mdone), .out_result(b_res), .out_valid(b_ov)
    );

    // Synchronous-read RAMs and a 2-cycle mac model for each instance
    always @(posedge clk) begin
        if (a_fen) a_frd <= fmem[a_faddr];
        if (a_wen) a_wrd <= wmem[a_waddr];
        if (b_fen) b_frd <= fmem[b_faddr];
        if (b_wen) b_wrd <= wmem[b_waddr];
        a_p_v   <= a_men;
        a_p_r   <= $signed({1'b0, a_mf}) * a_mw;
        a_mdone <= a_p_v;
        a_mres  <= a_p_r;
        b_p_v   <= b_men;
        b_p_r   <= $signed({1'b0, b_mf}) * b_mw;
        b_mdone <= b_p_v;
        b_mres  <= b_p_r;
    end

    typedef struct {
        longint val;
        int     cyc;
    } exp_t;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic longint fin(input longint s);
        logic signed [31:0] t;
        t = s[31:0];
`ifdef MAC_SEQ_RELU_EN
        if (t < 0) t = 0;
`endif
        return longint'(t);
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rstn === 1'b1 && a_ov === 1'b1) begin
            if (qa.size() == 0) chk("a_spurious_valid", a_ov, 0);
            else begin
                ea = qa.pop_front();
                chk("a_result", a_res, ea.val);
                chk("a_valid_cycle", cyc, ea.cyc);
                $display("a: out_valid cycle=%0d result=%0d", cyc, a_res);
            end
        end
        if (rstn === 1'b1 && b_ov === 1'b1) begin
            if (qb.size() == 0) chk("b_spurious_valid", b_ov, 0);
            else begin
                eb = qb.pop_front();
                chk("b_result", b_res, eb.val);
                chk("b_valid_cycle", cyc, eb.cyc);
                $display("b: out_valid cycle=%0d result=%0d", cyc, b_res);
            end
        end
    end

    task automatic chk_a_zero(input string pfx);
        chk({pfx, "_busy"},      a_busy,  0);
        chk({pfx, "_feat_en"},   a_fen,   0);
        chk({pfx, "_wgt_en"},    a_wen,   0);
        chk({pfx, "_mac_en"},    a_men,   0);
        chk({pfx, "_out_valid"}, a_ov,    0);
        chk({pfx, "_feat_addr"}, a_faddr, 0);
        chk({pfx, "_wgt_addr"},  a_waddr, 0);
        chk({pfx, "_mac_feat"},  a_mf,    0);
        chk({pfx, "_mac_wgt"},   a_mw,    0);
        chk({pfx, "_result"},    a_res,   0);
    endtask

    int     s;
    longint sum;
    int     wrap_addr [4];

    initial begin
        rstn = 1'b0;
        a_start = 1'b0; a_wb = '0; a_bias = '0;
        b_start = 1'b0; b_wb = 13'd2000; b_bias = '0;
        wrap_addr[0] = 8190; wrap_addr[1] = 8191; wrap_addr[2] = 0; wrap_addr[3] = 1;
        step(3);
        chk_a_zero("reset");
        rstn = 1'b1;
        step(1);

        // Test 1: features 1..4, weights 1, bias 0 -> 10
        for (int i = 0; i < 4; i++) begin
            fmem[i] = 8'(i + 1);
            wmem[100 + i] = 8'sd1;
        end
        a_start = 1'b1; a_wb = 13'd100; a_bias = 16'sd0;
        s = cyc;
        qa.push_back('{fin(10), s + 9});
        step(1);
        a_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t1_feat_addr", a_faddr, i);
            chk("t1_wgt_addr",  a_waddr, 100 + i);
            chk("t1_feat_en",   a_fen,   1);
            chk("t1_busy",      a_busy,  1);
            chk("t1_mac_en",    a_men,   (i >= 1) ? 1 : 0);
            if (i >= 1) chk("t1_mac_feature", a_mf, i);
            step(1);
        end
        chk("t1_feat_en_off", a_fen, 0);
        chk("t1_mac_en_last", a_men, 1);
        step(3);
        chk("t1_busy_last", a_busy, 1);
        step(1);
        chk("t1_busy_at_valid", a_busy, 0);
        step(2);
        chk("t1_valid_pulse", a_ov, 0);
        chk("t1_result_held", a_res, fin(10));

        // Test 2: 255 x -128 four times, bias -5
        for (int i = 0; i < 4; i++) begin
            fmem[i] = 8'd255;
            wmem[200 + i] = -8'sd128;
        end
        a_start = 1'b1; a_wb = 13'd200; a_bias = -16'sd5;
        s = cyc;
        qa.push_back('{fin(-130565), s + 9});
        step(1);
        a_start = 1'b0;
        step(10);

        // Test 3: weight address wraps past 8191
        for (int i = 0; i < 4; i++) fmem[i] = 8'(i + 1);
        wmem[8190] = 8'sd3; wmem[8191] = -8'sd2; wmem[0] = 8'sd7; wmem[1] = -8'sd1;
        a_start = 1'b1; a_wb = 13'd8190; a_bias = 16'sd7;
        s = cyc;
        qa.push_back('{fin(23), s + 9});
        step(1);
        a_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t3_wgt_addr_wrap", a_waddr, wrap_addr[i]);
            step(1);
        end
        step(6);

        // Test 4: starts while busy are ignored; start in the out_valid cycle is accepted
        a_start = 1'b1;
        s = cyc;
        qa.push_back('{fin(23), s + 9});
        step(1);
        a_start = 1'b0;
        step(2);
        a_start = 1'b1;
        step(1);
        a_start = 1'b0;
        step(1);
        a_start = 1'b1;
        step(1);
        a_start = 1'b0;
        step(3);
        chk("t4_valid_now", a_ov, 1);
        a_start = 1'b1; a_bias = -16'sd20;
        qa.push_back('{fin(-4), s + 18});
        step(1);
        a_start = 1'b0;
        chk("t4_second_busy", a_busy, 1);
        step(10);

        // Test 5: asynchronous reset mid-run, then a clean run
        a_wb = 13'd100; a_bias = 16'sd23;
        for (int i = 0; i < 4; i++) fmem[i] = 8'(i + 1);
        a_start = 1'b1;
        step(1);
        a_start = 1'b0;
        step(5);
        rstn = 1'b0;
        #1;
        chk_a_zero("t5_async");
        step(3);
        rstn = 1'b1;
        step(2);
        a_bias = 16'sd3;
        a_start = 1'b1;
        s = cyc;
        qa.push_back('{fin(13), s + 9});
        step(1);
        a_start = 1'b0;
        step(10);

        // Test 6: 784 random products against a reference sum
        sum = 0;
        for (int i = 0; i < 784; i++) begin
            fmem[i] = 8'($urandom_range(0, 255));
            wmem[2000 + i] = 8'($urandom_range(0, 255));
            sum += longint'(fmem[i]) * longint'(wmem[2000 + i]);
        end
        b_bias = 16'($urandom_range(0, 65535));
        sum += longint'(b_bias);
        b_start = 1'b1;
        s = cyc;
        qb.push_back('{fin(sum), s + 789});
        step(1);
        b_start = 1'b0;
        chk("t6_busy", b_busy, 1);
        step(800);

        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencer for one `mac` unit, computing one fully-connected neuron per run in the MNIST datapath. On `start` it streams N_INPUTS feature/weight pairs from two synchronous-read memories into the `mac`. It accumulates the returned 17-bit products, adds a per-neuron bias and presents one signed result with a single-cycle valid pulse. It sits between the layer scheduler, which issues `start`, and the `mac` instance plus the feature and weight RAMs.

## Interface
- `N_INPUTS`, 784, number of products per neuron (≥1)
- `F_ADDR_W`, 10, feature memory address width (2^F_ADDR_W ≥ N_INPUTS)
- `W_ADDR_W`, 13, weight memory address width
- `ACC_W`, 32, accumulator/result width (≥18)
- `clk` in 1: single clock, all logic on rising edge
- `rstn` in 1: asynchronous, active-low reset
- `start` in 1: begin one neuron; sampled only in IDLE
- `weight_base` in W_ADDR_W: weight address of element 0, latched on accepted `start`
- `bias` in 16 signed: latched on accepted `start`
- `busy` out 1: high from the cycle after accepted `start` through the `out_valid` cycle exclusive
- `feat_rd_en` / `feat_rd_addr` out 1 / F_ADDR_W: feature RAM read; data returns next cycle
- `feat_rdata` in 8 unsigned: feature RAM data
- `wgt_rd_en` / `wgt_rd_addr` out 1 / W_ADDR_W: weight RAM read; data returns next cycle
- `wgt_rdata` in 8 signed: weight RAM data
- `mac_en` out 1; `mac_feature` out 8; `mac_weight` out 8 signed: drive `mac`
- `mac_result` in 17 signed; `mac_done` in 1: from `mac`; 2-cycle latency from `mac_en`
- `out_result` out ACC_W signed: neuron output, held until next `out_valid`
- `out_valid` out 1: one-cycle pulse

## Operation
- FSM states: IDLE, ISSUE, DRAIN, BIAS.
  - IDLE → ISSUE on `start`: latch `weight_base`/`bias`, clear issue count, done count and acc.
  - ISSUE: assert both read enables. `feat_rd_addr` = i and `wgt_rd_addr` = weight_base + i, for i = 0..N_INPUTS-1, one per cycle. After i = N_INPUTS-1 → DRAIN.
  - DRAIN: wait until done count == N_INPUTS, then → BIAS.
  - BIAS: register `out_result` = acc + sign-extended bias; pulse `out_valid` next cycle; → IDLE.
- `mac_en` = read enable delayed one cycle. `mac_feature`/`mac_weight` are `feat_rdata`/`wgt_rdata` passed through combinationally, with no extra register.
- On each `mac_done`: acc += sign-extended `mac_result`, and done count increments. `mac_done` in IDLE is ignored.
- Arithmetic is two's complement at ACC_W and wraps on overflow. No saturation.
- `wgt_rd_addr` wraps modulo 2^W_ADDR_W.
- `start` while busy is ignored, with no queueing.
- `start` in the same cycle as `out_valid` is accepted: FSM is already IDLE in that cycle.

## Timing
- Reset values: `busy`, `feat_rd_en`, `wgt_rd_en`, `mac_en`, `out_valid` = 0. `feat_rd_addr`, `wgt_rd_addr`, `mac_feature`, `mac_weight` = 0. `out_result` = 0. FSM = IDLE, counters and acc = 0.
- Cycle 0: `start` sampled.
- Cycles 1..N: ISSUE, addresses 0..N-1.
- Cycles 2..N+1: `mac_en` = 1.
- Cycles 4..N+3: `mac_done` expected.
- Cycle N+4: BIAS.
- Cycle N+5: `out_valid` = 1, `busy` = 0.
- Throughput: one product per cycle, no bubbles. Back-to-back neurons cost N+5 cycles each.
- Reset mid-run: all state returns to reset values immediately. No `out_valid` is produced for the aborted neuron.

## Configuration
- `MAC_SEQ_RELU_EN` defined: `out_result` = max(0, acc + bias). Negative sums give 0; the compare is done in the BIAS stage, with no added latency.
- Undefined: `out_result` = acc + bias, raw signed.

## Test plan
- N_INPUTS = 4, features {1,2,3,4}, weights {1,1,1,1}, bias 0, start at cycle 0 → `out_valid` at cycle 9 with `out_result` = 10. Addresses 0..3 on cycles 1..4; `busy` high on cycles 1..8.
- N_INPUTS = 4, features {255 ×4}, weights {-128 ×4}, bias -5 → -130565 without RELU; 0 with `MAC_SEQ_RELU_EN`.
- `weight_base` = 2^13-2, N = 4 → `wgt_rd_addr` sequence 8190, 8191, 0, 1.
- `start` pulsed at cycles 3 and 5 during a run → ignored; exactly one `out_valid`. `start` in the `out_valid` cycle → second run begins, with the second `out_valid` N+5 cycles later.
- `rstn` low at cycle 6 of a run → all outputs 0 asynchronously; no `out_valid`. After release, a new `start` gives the correct result.
- N_INPUTS = 784 with random data vs. reference model → `out_result` matches; `out_valid` at cycle 789.
